cache_seq_ctrl: RTL and testbench
=================================

Name: cache_seq_ctrl

Overview:
Sequencing controller for the 2-way set-associative lab cache: 4 sets, 3-bit tag, 2-bit index, 3-bit data word, one word per line. It owns the tag, valid, dirty, LRU and data arrays. It accepts one CPU request at a time through a req/ready handshake. On a miss it sequences write-back and fill transactions to the backing RAM over a req/ack memory port.

Parameters:
TAG_W, 3, tag width; address width is TAG_W+IDX_W
IDX_W, 2, index width; number of sets is 2**IDX_W
DATA_W, 3, data word width (one word per line)

Ports:
clock  in  1  single clock; all state updates on posedge
resetn  in  1  reset, asynchronous and active-low
req  in  1  CPU request; accepted on the posedge where req=1 and ready=1
wren  in  1  1=write, 0=read; sampled on acceptance
addr  in  TAG_W+IDX_W  {tag, index}; sampled on acceptance
wdata  in  DATA_W  write data; sampled on acceptance
ready  out  1  controller idle, can accept a request
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  line data after the op (read result, or written value)
hit  out  1  1 if the completed op hit
wrback  out  1  1 if the completed op caused a dirty eviction
mem_req  out  1  memory transaction request
mem_we  out  1  1=write-back, 0=fill read
mem_addr  out  TAG_W+IDX_W  memory word address
mem_wdata  out  DATA_W  write-back data
mem_rdata  in  DATA_W  fill data; valid when mem_ack=1
mem_ack  in  1  one-cycle memory completion

Behaviour:
- Reset (resetn=0, async): state=IDLE. All valid, dirty and LRU bits cleared; data and tag arrays zeroed. ready=1. done=hit=wrback=mem_req=mem_we=0. rdata, mem_addr, mem_wdata = 0. Any in-flight request is discarded; mem_req drops without waiting for mem_ack.
- States: IDLE, LOOKUP, WRBACK, FILL, DONE. ready=1 only in IDLE.
- IDLE: on req=1, latch wren, addr and wdata, then go to LOOKUP. hit and wrback are cleared on acceptance.
- LOOKUP (exactly 1 cycle): compare the tag against both valid ways of set addr[IDX_W-1:0].
  - Hit: a read loads rdata from the hit way. A write stores wdata, sets dirty=1 and loads rdata=wdata. LRU points to the other way. hit=1. Go to DONE.
  - Miss, victim selection: an invalid way0 is chosen first, then an invalid way1, otherwise the way the LRU bit names (LRU=0 -> way0). Victim valid and dirty -> WRBACK. Otherwise a read goes to FILL, and a write installs directly (no fill) and goes to DONE.
- WRBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data, all held stable until mem_ack=1. On ack: wrback=1, victim dirty cleared, mem_req=0 on the next cycle. Then a read goes to FILL. A write installs at the victim (tag, data=wdata, valid=1, dirty=1, rdata=wdata) and goes to DONE.
- FILL: mem_req=1, mem_we=0, mem_addr=latched addr, held until mem_ack. On ack: victim gets tag, data=mem_rdata, valid=1, dirty=0; rdata=mem_rdata. Go to DONE.
- Every install or hit makes the accessed way MRU: LRU names the other way.
- DONE: done=1 for exactly one cycle, then IDLE. rdata, hit and wrback hold until the next acceptance.
- Latency: a hit gives done 2 cycles after acceptance. A miss adds the cycles until each mem_ack, plus 1 cycle per memory transaction.
- Back-to-back memory transactions: mem_req deasserts for at least 1 cycle between WRBACK and FILL.
- Ignored inputs: req while ready=0; mem_ack in IDLE, LOOKUP or DONE. mem_rdata is sampled only with mem_ack in FILL.
- Any write makes its line dirty. Read fills are always clean.

Test Plan:
1. Reset, then read addr=5'b01110 -> mem_req=1, mem_we=0, mem_addr=01110; memory acks with 3'b101 after 3 cycles -> done, rdata=5, hit=0, wrback=0. Re-read 01110 -> hit=1, rdata=5, done 2 cycles after acceptance, no mem_req.
2. Write 01110 with wdata=3'b010 -> hit=1, no memory traffic. Read 01110 -> rdata=2, hit=1.
3. Read 00110 (fills way1, clean). Then read 11110 -> victim is way0 (dirty, tag 011). Expect WRBACK with mem_we=1, mem_addr=01110, mem_wdata=2, a mem_req gap, then FILL with mem_addr=11110. Result: done with wrback=1, hit=0.
4. After reset, write 10001 with wdata=7 -> no mem_req, hit=0, wrback=0. Read 10001 -> hit=1, rdata=7.
5. Assert resetn=0 during FILL with mem_req=1 -> mem_req=0 immediately and ready=1. After release, read of a previously hit line -> miss.
6. Hold req=1 continuously; pulse mem_ack while in IDLE -> exactly one accept per IDLE visit, and the spurious ack has no effect on state or arrays.

Source files
------------

// File: rtl/cache_seq_ctrl_if.sv
// rtl/cache_seq_ctrl_if.sv - CPU request and backing-memory signal bundle for cache_seq_ctrl
//
// Groups the CPU request/response handshake and the memory port.
// The master modport is the requester/memory side. The slave modport is the controller side.
//   CPU:    req, wren, addr, wdata -> ready, done, rdata, hit, wrback
//   Memory: mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
interface cache_seq_ctrl_if #(
  parameter int TAG_W  = 3,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 3
);
  logic                     req;
  logic                     wren;
  logic [TAG_W+IDX_W-1:0]   addr;
  logic [DATA_W-1:0]        wdata;
  logic                     ready;
  logic                     done;
  logic [DATA_W-1:0]        rdata;
  logic                     hit;
  logic                     wrback;
  logic                     mem_req;
  logic                     mem_we;
  logic [TAG_W+IDX_W-1:0]   mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_ack;

  modport master (
    output req, wren, addr, wdata, mem_rdata, mem_ack,
    input  ready, done, rdata, hit, wrback, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, wren, addr, wdata, mem_rdata, mem_ack,
    output ready, done, rdata, hit, wrback, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_seq_ctrl.sv
// rtl/cache_seq_ctrl.sv - 2-way set-associative cache sequencing controller
//
// Owns the tag, valid, dirty, LRU and data arrays of a small write-back cache.
// It serves one CPU request at a time and issues write-back and fill transactions on a miss.
// Ports:
//   clock   single clock, all state updates on posedge
//   resetn  asynchronous active-low reset
//   bus     cache_seq_ctrl_if.slave (CPU handshake and memory port)
module cache_seq_ctrl #(
  parameter int TAG_W  = 3,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  cache_seq_ctrl_if.slave  bus
);
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int NSETS  = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WRBACK = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                victim_q, victim_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;
  logic                wrback_q, wrback_d;
  logic                mem_req_q, mem_req_d;

  logic [TAG_W-1:0]    tag_q   [2][NSETS];
  logic [TAG_W-1:0]    tag_d   [2][NSETS];
  logic [DATA_W-1:0]   data_q  [2][NSETS];
  logic [DATA_W-1:0]   data_d  [2][NSETS];
  logic                valid_q [2][NSETS];
  logic                valid_d [2][NSETS];
  logic                dirty_q [2][NSETS];
  logic                dirty_d [2][NSETS];
  logic                lru_q   [NSETS];
  logic                lru_d   [NSETS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit0, hit1, vsel;

  // Install request raised by the FSM and applied after the case statement.
  // This lets the write-miss, write-back and fill paths share one update.
  logic                do_install;
  logic                inst_way;
  logic [DATA_W-1:0]   inst_data;
  logic                inst_dirty;

  assign idx  = addr_q[IDX_W-1:0];
  assign tag  = addr_q[ADDR_W-1:IDX_W];
  assign hit0 = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1 = valid_q[1][idx] && (tag_q[1][idx] == tag);
  // Victim choice: an empty way0, then an empty way1, otherwise the LRU way.
  assign vsel = !valid_q[0][idx] ? 1'b0 :
                !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      victim_q  <= 1'b0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      wrback_q  <= 1'b0;
      mem_req_q <= 1'b0;
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < NSETS; s++) begin
          tag_q[w][s]   <= '0;
          data_q[w][s]  <= '0;
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < NSETS; s++) begin
        lru_q[s] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      victim_q  <= victim_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      wrback_q  <= wrback_d;
      mem_req_q <= mem_req_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      lru_q     <= lru_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    wrback_d   = wrback_q;
    mem_req_d  = mem_req_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    do_install = 1'b0;
    inst_way   = 1'b0;
    inst_data  = '0;
    inst_dirty = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          wren_d   = bus.wren;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          hit_d    = 1'b0;
          wrback_d = 1'b0;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit0 || hit1) begin
          inst_way = hit0 ? 1'b0 : 1'b1;
          if (wren_q) begin
            data_d[inst_way][idx]  = wdata_q;
            dirty_d[inst_way][idx] = 1'b1;
            rdata_d                = wdata_q;
          end else begin
            rdata_d = data_q[inst_way][idx];
          end
          lru_d[idx] = ~inst_way;
          hit_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          victim_d = vsel;
          if (valid_q[vsel][idx] && dirty_q[vsel][idx]) begin
            mem_req_d = 1'b1;
            state_d   = S_WRBACK;
          end else if (!wren_q) begin
            mem_req_d = 1'b1;
            state_d   = S_FILL;
          end else begin
            // A write miss into a clean or empty way needs no fill because the line is one word.
            do_install = 1'b1;
            inst_way   = vsel;
            inst_data  = wdata_q;
            inst_dirty = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_WRBACK: begin
        if (bus.mem_ack) begin
          mem_req_d                 = 1'b0;
          wrback_d                  = 1'b1;
          dirty_d[victim_q][idx]    = 1'b0;
          if (wren_q) begin
            do_install = 1'b1;
            inst_way   = victim_q;
            inst_data  = wdata_q;
            inst_dirty = 1'b1;
            state_d    = S_DONE;
          end else begin
            // FILL is entered with mem_req low. This gives the gap cycle between transactions.
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          do_install = 1'b1;
          inst_way   = victim_q;
          inst_data  = bus.mem_rdata;
          inst_dirty = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_install) begin
      tag_d[inst_way][idx]   = tag;
      data_d[inst_way][idx]  = inst_data;
      valid_d[inst_way][idx] = 1'b1;
      dirty_d[inst_way][idx] = inst_dirty;
      lru_d[idx]             = ~inst_way;
      rdata_d                = inst_data;
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.rdata   = rdata_q;
  assign bus.hit     = hit_q;
  assign bus.wrback  = wrback_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we  = (state_q == S_WRBACK);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == S_WRBACK) begin
      bus.mem_addr  = {tag_q[victim_q][idx], idx};
      bus.mem_wdata = data_q[victim_q][idx];
    end else if (state_q == S_FILL) begin
      bus.mem_addr = addr_q;
    end
  end
endmodule

// File: tb/tb_cache_seq_ctrl.sv
// tb/tb_cache_seq_ctrl.sv - directed scoreboard bench for cache_seq_ctrl
module tb_cache_seq_ctrl;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 2;
  localparam int DATA_W = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  cache_seq_ctrl_if #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) mif ();

  cache_seq_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (mif.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] rdata;
    logic       hit;
    logic       wrback;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [2:0] wdata;
  } txn_t;
  txn_t txq[$];

  // Backing memory model with a programmable ack delay.
  logic [2:0] bmem [32];
  int         mem_lat     = 3;
  int         mcnt        = 0;
  logic       model_ack   = 1'b0;
  logic [2:0] model_rdata = '0;
  logic       spur_ack    = 1'b0;
  logic [2:0] spur_data   = '0;

  assign mif.mem_ack   = model_ack | spur_ack;
  assign mif.mem_rdata = spur_ack ? spur_data : model_rdata;

  always @(posedge clock) begin
    #1;
    if (!mif.mem_req || model_ack) begin
      model_ack = 1'b0;
      mcnt      = 0;
    end else if (mcnt == mem_lat) begin
      model_ack = 1'b1;
      mcnt      = 0;
      txq.push_back('{we: mif.mem_we, addr: mif.mem_addr, wdata: mif.mem_wdata});
      if (mif.mem_we) bmem[mif.mem_addr] = mif.mem_wdata;
      else            model_rdata = bmem[mif.mem_addr];
    end else begin
      mcnt++;
    end
  end

  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   rise_cnt = 0;
  logic prev_req = 1'b0;
  always @(negedge clock) begin
    if (resetn && mif.req && mif.ready) acc_cnt++;
    if (mif.done) done_cnt++;
    if (mif.mem_req && !prev_req) rise_cnt++;
    prev_req = mif.mem_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [4:0] a, input logic [2:0] wd,
                       input logic [2:0] e_rdata, input logic e_hit, input logic e_wb);
    int n = 0;
    while (!mif.ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    check("ready_before_issue", mif.ready, 1);
    mif.req   = 1'b1;
    mif.wren  = wr;
    mif.addr  = a;
    mif.wdata = wd;
    sb.push_back('{rdata: e_rdata, hit: e_hit, wrback: e_wb});
    @(posedge clock); #1;
    mif.req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    exp_t e;
    int cyc = 1;
    while (!mif.done && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    lat = cyc;
    check({tag, "_done_seen"}, mif.done, 1);
    check({tag, "_sb_pending"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"},  mif.rdata,  e.rdata);
      check({tag, "_hit"},    mif.hit,    e.hit);
      check({tag, "_wrback"}, mif.wrback, e.wrback);
    end
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, mif.done, 0);
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [4:0] a,
                       input logic [2:0] wd, input logic [2:0] e_rdata,
                       input logic e_hit, input logic e_wb, output int lat);
    issue(wr, a, wd, e_rdata, e_hit, e_wb);
    wait_done(tag, lat);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int lat;
    int r0, a0, d0, n;
    for (int i = 0; i < 32; i++) bmem[i] = 3'(i);
    bmem[14] = 3'b101;
    bmem[6]  = 3'b011;
    bmem[30] = 3'b110;
    bmem[17] = 3'b100;
    mif.req = 1'b0; mif.wren = 1'b0; mif.addr = '0; mif.wdata = '0;

    // Reset state, observed while reset is held.
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready",     mif.ready,     1);
    check("rst_done",      mif.done,      0);
    check("rst_hit",       mif.hit,       0);
    check("rst_wrback",    mif.wrback,    0);
    check("rst_mem_req",   mif.mem_req,   0);
    check("rst_mem_we",    mif.mem_we,    0);
    check("rst_rdata",     mif.rdata,     0);
    check("rst_mem_addr",  mif.mem_addr,  0);
    check("rst_mem_wdata", mif.mem_wdata, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // 1: cold read miss with fill, then a hit.
    r0 = rise_cnt;
    do_op("t1_miss", 1'b0, 5'b01110, 3'd0, 3'b101, 1'b0, 1'b0, lat);
    check("t1_miss_latency", lat, 6);
    check("t1_fill_count", txq.size(), 1);
    if (txq.size() >= 1) begin
      check("t1_fill_we",   txq[0].we,   0);
      check("t1_fill_addr", txq[0].addr, 5'b01110);
    end
    check("t1_mem_req_rises", rise_cnt - r0, 1);
    txq.delete();
    r0 = rise_cnt;
    do_op("t1_hit", 1'b0, 5'b01110, 3'd0, 3'b101, 1'b1, 1'b0, lat);
    check("t1_hit_latency", lat, 2);
    check("t1_hit_no_mem", rise_cnt - r0, 0);

    // 2: write hit makes the line dirty without memory traffic.
    r0 = rise_cnt;
    do_op("t2_wr_hit", 1'b1, 5'b01110, 3'b010, 3'b010, 1'b1, 1'b0, lat);
    do_op("t2_rd_hit", 1'b0, 5'b01110, 3'd0, 3'b010, 1'b1, 1'b0, lat);
    check("t2_no_mem", rise_cnt - r0, 0);

    // 3: fill way1, then evict dirty way0 via write-back followed by fill.
    do_op("t3_fill_w1", 1'b0, 5'b00110, 3'd0, 3'b011, 1'b0, 1'b0, lat);
    txq.delete();
    r0 = rise_cnt;
    do_op("t3_evict", 1'b0, 5'b11110, 3'd0, 3'b110, 1'b0, 1'b1, lat);
    check("t3_txn_count", txq.size(), 2);
    if (txq.size() >= 2) begin
      check("t3_wb_we",    txq[0].we,    1);
      check("t3_wb_addr",  txq[0].addr,  5'b01110);
      check("t3_wb_wdata", txq[0].wdata, 3'b010);
      check("t3_fill_we",  txq[1].we,    0);
      check("t3_fill_addr", txq[1].addr, 5'b11110);
    end
    check("t3_mem_req_gap", rise_cnt - r0, 2);
    check("t3_bmem_written", bmem[14], 3'b010);
    txq.delete();

    // 4: write miss into an empty set installs directly.
    apply_reset();
    r0 = rise_cnt;
    do_op("t4_wr_miss", 1'b1, 5'b10001, 3'b111, 3'b111, 1'b0, 1'b0, lat);
    do_op("t4_rd_hit",  1'b0, 5'b10001, 3'd0,   3'b111, 1'b1, 1'b0, lat);
    check("t4_no_mem", rise_cnt - r0, 0);

    // 5: reset in the middle of a fill.
    mem_lat = 30;
    issue(1'b0, 5'b00011, 3'd0, 3'd0, 1'b0, 1'b0);
    n = 0;
    while (!mif.mem_req && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("t5_mem_req_up", mif.mem_req, 1);
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    check("t5_rst_mem_req", mif.mem_req, 0);
    check("t5_rst_ready",   mif.ready,   1);
    sb.delete();
    @(posedge clock); #1;
    resetn  = 1'b1;
    mem_lat = 3;
    txq.delete();
    do_op("t5_after_rst", 1'b0, 5'b10001, 3'd0, 3'b100, 1'b0, 1'b0, lat);
    txq.delete();

    // 6: req held high accepts once per IDLE visit; a stray ack in IDLE is ignored.
    a0 = acc_cnt; d0 = done_cnt; r0 = rise_cnt;
    mif.wren = 1'b0; mif.addr = 5'b10001; mif.wdata = 3'd0;
    mif.req  = 1'b1;
    repeat (9) begin
      @(posedge clock); #1;
    end
    mif.req = 1'b0;
    check("t6_accepts", acc_cnt - a0, 3);
    check("t6_dones",   done_cnt - d0, 3);
    check("t6_hold_hit", mif.hit, 1);
    check("t6_hold_rdata", mif.rdata, 3'b100);
    spur_data = 3'b001;
    spur_ack  = 1'b1;
    @(posedge clock); #1;
    spur_ack = 1'b0;
    check("t6_spur_ready",   mif.ready,   1);
    check("t6_spur_mem_req", mif.mem_req, 0);
    check("t6_spur_rdata",   mif.rdata,   3'b100);
    do_op("t6_after_spur", 1'b0, 5'b10001, 3'd0, 3'b100, 1'b1, 1'b0, lat);
    check("t6_no_mem", rise_cnt - r0, 0);
    check("t6_no_txn", txq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
